// File: rtl/gp_cmd_pkg.sv
// Shared command-buffer types: header layout, ring address width and fetch FSM states.
// Used by both the command writer and the command fetch stage.
package gp_cmd_pkg;

    localparam int CMD_ADDR_W = 11;

    typedef struct packed {
        logic [7:0] len;
        logic [7:0] id;
    } cmd_hdr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/gp_cmd_fetch.sv
// Command fetch: reads committed ring-buffer words from the command RAM, frames them
// into header+payload packets and hands them out one beat at a time over valid/ready.
module gp_cmd_fetch
    import gp_cmd_pkg::*;
#(
    parameter int ADDR_W  = CMD_ADDR_W,
    parameter int MAX_LEN = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [15:0]       ram_rdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [15:0]       cmd_data,
    output logic              cmd_first,
    output logic              cmd_last,
    output logic [7:0]        cmd_id,
    output logic [7:0]        cmd_len,
    output logic              err_len
);

    localparam logic [7:0]        MAX_LEN_C = 8'(MAX_LEN);
    localparam logic [ADDR_W-1:0] ONE_C     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_C    = ADDR_W'(0);

    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] avail_s;
    logic [ADDR_W-1:0] avail_after_s;
    logic              ram_re_r;
    logic              cmd_valid_r;
    logic [15:0]       cmd_data_r;
    logic              cmd_first_r;
    logic              cmd_last_r;
    logic [7:0]        cmd_id_r;
    logic [7:0]        cmd_len_r;
    logic              err_len_r;
    logic              in_pkt_r;
    logic [7:0]        remaining_r;
    cmd_hdr_t          hdr_s;
    logic              hs_s;
    logic              drop_s;
    logic              load_s;

    // Next-state decode plus the drop/load strobes for the word arriving in WAIT.
    always_comb begin
        hdr_s         = cmd_hdr_t'(ram_rdata);
        avail_s       = wr_ptr - rd_ptr_r;
        avail_after_s = wr_ptr - (rd_ptr_r + ONE_C);
        hs_s          = cmd_valid_r && cmd_ready;
        drop_s        = 1'b0;
        load_s        = 1'b0;
        state_nx_s    = state_r;
        case (state_r)
            IDLE: begin
                if (avail_s != ZERO_C) begin
                    state_nx_s = RD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD: begin
                state_nx_s = WAIT;
            end
            WAIT: begin
                if (!in_pkt_r && (hdr_s.len > MAX_LEN_C)) begin
                    drop_s     = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    load_s     = 1'b1;
                    state_nx_s = OUT;
                end
            end
            OUT: begin
                // The IDLE avail test is folded in here (against the post-increment
                // pointer) so back-to-back beats sustain one per three cycles.
                if (hs_s) begin
                    if (avail_after_s != ZERO_C) begin
                        state_nx_s = RD;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    state_nx_s = OUT;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, pointer, framing and registered output updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rd_ptr_r    <= ZERO_C;
            ram_re_r    <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_data_r  <= 16'h0000;
            cmd_first_r <= 1'b0;
            cmd_last_r  <= 1'b0;
            cmd_id_r    <= 8'h00;
            cmd_len_r   <= 8'h00;
            err_len_r   <= 1'b0;
            in_pkt_r    <= 1'b0;
            remaining_r <= 8'h00;
        end else begin
            state_r     <= state_nx_s;
            ram_re_r    <= (state_nx_s == RD);
            cmd_valid_r <= (state_nx_s == OUT);
            err_len_r   <= drop_s;
            if (drop_s || ((state_r == OUT) && hs_s)) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            if (load_s) begin
                cmd_data_r  <= ram_rdata;
                cmd_first_r <= !in_pkt_r;
                if (!in_pkt_r) begin
                    cmd_id_r    <= hdr_s.id;
                    cmd_len_r   <= hdr_s.len;
                    remaining_r <= hdr_s.len;
                    cmd_last_r  <= (hdr_s.len == 8'd0);
                end else begin
                    cmd_last_r  <= (remaining_r == 8'd1);
                end
            end
            // Header handshake keeps the loaded length; payload handshakes count down.
            if ((state_r == OUT) && hs_s) begin
                in_pkt_r <= !cmd_last_r;
                if (!cmd_first_r) begin
                    remaining_r <= remaining_r - 8'd1;
                end
            end
        end
    end

    assign rd_ptr    = rd_ptr_r;
    assign ram_re    = ram_re_r;
    assign ram_raddr = rd_ptr_r;
    assign cmd_valid = cmd_valid_r;
    assign cmd_data  = cmd_data_r;
    assign cmd_first = cmd_first_r;
    assign cmd_last  = cmd_last_r;
    assign cmd_id    = cmd_id_r;
    assign cmd_len   = cmd_len_r;
    assign err_len   = err_len_r;

endmodule

// File: tb/tb_gp_cmd_fetch.sv
// Self-checking bench for gp_cmd_fetch: behavioural RAM, vector table of ring words with
// expected beats, and a scoreboard queue popped on every handshake.
module tb_gp_cmd_fetch;
    import gp_cmd_pkg::*;

    localparam int AW = 11;

    typedef struct packed {
        logic [15:0] data;
        logic        first;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  len;
    } beat_t;

    typedef struct packed {
        logic [15:0] word;
        logic        drop;
        beat_t       exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [15:0]   ram_rdata;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [15:0]   cmd_data;
    logic          cmd_first;
    logic          cmd_last;
    logic [7:0]    cmd_id;
    logic [7:0]    cmd_len;
    logic          err_len;

    logic [15:0]   mem [0:(1<<AW)-1];
    beat_t         exp_q[$];
    int            hs_cyc[$];
    vec_t          tbl [0:14];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            err_cnt = 0;
    int            cyc = 0;
    logic [AW-1:0] wp;

    gp_cmd_fetch #(.ADDR_W(AW), .MAX_LEN(4)) dut (
        .clk(clk), .rst(rst), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_first(cmd_first), .cmd_last(cmd_last), .cmd_id(cmd_id),
        .cmd_len(cmd_len), .err_len(err_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    // Scoreboard: every handshake pops one expected beat.
    always @(negedge clk) begin
        beat_t act;
        beat_t e;
        if (err_len) err_cnt = err_cnt + 1;
        if (cmd_valid && cmd_ready) begin
            act = '{cmd_data, cmd_first, cmd_last, cmd_id, cmd_len};
            hs_cyc.push_back(cyc);
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL beat_unexpected: got data=%h first=%b last=%b id=%h len=%h, expected no beat",
                         act.data, act.first, act.last, act.id, act.len);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_bad = n_bad + 1;
                    $display("FAIL beat: got data=%h first=%b last=%b id=%h len=%h, expected data=%h first=%b last=%b id=%h len=%h",
                             act.data, act.first, act.last, act.id, act.len,
                             e.data, e.first, e.last, e.id, e.len);
                end
            end
        end
    end

    function automatic vec_t mk(input logic [15:0] w, input logic d, input logic f,
                                input logic l, input logic [7:0] id, input logic [7:0] len);
        vec_t v;
        v.word = w;
        v.drop = d;
        v.exp  = '{w, f, l, id, len};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic put(input int idx);
        mem[wp] = tbl[idx].word;
        if (!tbl[idx].drop) exp_q.push_back(tbl[idx].exp);
        wp = wp + 1'b1;
    endtask

    task automatic commit();
        @(posedge clk) #1;
        wr_ptr = wp;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_ptr"},    32'(rd_ptr),    32'd0);
        chk({tag, "_ram_re"},    32'(ram_re),    32'd0);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_cmd_data"},  32'(cmd_data),  32'd0);
        chk({tag, "_first"},     32'(cmd_first), 32'd0);
        chk({tag, "_last"},      32'(cmd_last),  32'd0);
        chk({tag, "_id"},        32'(cmd_id),    32'd0);
        chk({tag, "_len"},       32'(cmd_len),   32'd0);
        chk({tag, "_err_len"},   32'(err_len),   32'd0);
    endtask

    initial begin
        int err0;
        int t0;
        logic bad;
        tbl[0]  = mk(16'h0203, 1'b0, 1'b1, 1'b0, 8'h03, 8'h02);
        tbl[1]  = mk(16'hAAAA, 1'b0, 1'b0, 1'b0, 8'h03, 8'h02);
        tbl[2]  = mk(16'hBBBB, 1'b0, 1'b0, 1'b1, 8'h03, 8'h02);
        tbl[3]  = mk(16'h0007, 1'b0, 1'b1, 1'b1, 8'h07, 8'h00);
        tbl[4]  = mk(16'h0311, 1'b0, 1'b1, 1'b0, 8'h11, 8'h03);
        tbl[5]  = mk(16'h5001, 1'b0, 1'b0, 1'b0, 8'h11, 8'h03);
        tbl[6]  = mk(16'h5002, 1'b0, 1'b0, 1'b0, 8'h11, 8'h03);
        tbl[7]  = mk(16'h5003, 1'b0, 1'b0, 1'b1, 8'h11, 8'h03);
        tbl[8]  = mk(16'h0501, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        tbl[9]  = mk(16'h0102, 1'b0, 1'b1, 1'b0, 8'h02, 8'h01);
        tbl[10] = mk(16'h1234, 1'b0, 1'b0, 1'b1, 8'h02, 8'h01);
        tbl[11] = mk(16'h0309, 1'b0, 1'b1, 1'b0, 8'h09, 8'h03);
        tbl[12] = mk(16'hC001, 1'b0, 1'b0, 1'b0, 8'h09, 8'h03);
        tbl[13] = mk(16'h0142, 1'b0, 1'b1, 1'b0, 8'h42, 8'h01);
        tbl[14] = mk(16'h7777, 1'b0, 1'b0, 1'b1, 8'h42, 8'h01);

        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
        rst = 1'b1;
        wr_ptr = '0;
        cmd_ready = 1'b0;
        wp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        cmd_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Basic packet with latency and throughput checks.
        for (int i = 0; i <= 2; i++) put(i);
        hs_cyc.delete();
        commit();
        @(posedge clk) #1;
        chk("basic_ram_re_t1", 32'(ram_re), 32'd1);
        chk("basic_raddr_t1", 32'(ram_raddr), 32'd0);
        @(posedge clk) #1;
        chk("basic_valid_t2", 32'(cmd_valid), 32'd0);
        @(posedge clk) #1;
        chk("basic_valid_t3", 32'(cmd_valid), 32'd1);
        wait_drain("basic", 40);
        chk("basic_rd_ptr", 32'(rd_ptr), 32'd3);
        chk("basic_hs_count", 32'(hs_cyc.size()), 32'd3);
        if (hs_cyc.size() == 3) begin
            chk("basic_gap0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
            chk("basic_gap1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
        end

        // Zero-length header under backpressure.
        cmd_ready = 1'b0;
        put(3);
        commit();
        t0 = 0;
        while (!cmd_valid && t0 < 20) begin
            @(posedge clk) #1;
            t0++;
        end
        chk("bp_valid_seen", 32'(cmd_valid), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk) #1;
            if (!cmd_valid || cmd_data !== 16'h0007 || !cmd_first || !cmd_last ||
                cmd_id !== 8'h07 || cmd_len !== 8'h00 || rd_ptr !== 11'd3) bad = 1'b1;
        end
        chk("bp_hold_stable", 32'(bad), 32'd0);
        cmd_ready = 1'b1;
        wait_drain("bp", 20);
        chk("bp_rd_ptr", 32'(rd_ptr), 32'd4);

        // Advance to 2046 with zero-length headers, then a packet straddling the wrap.
        for (int k = 4; k < 2046; k++) begin
            logic [7:0] kid;
            kid = 8'(k);
            mem[k] = {8'h00, kid};
            exp_q.push_back('{{8'h00, kid}, 1'b1, 1'b1, kid, 8'h00});
        end
        wp = 11'd2046;
        commit();
        wait_drain("fill", 8000);
        chk("fill_rd_ptr", 32'(rd_ptr), 32'd2046);
        for (int i = 4; i <= 7; i++) put(i);
        commit();
        wait_drain("wrap", 60);
        chk("wrap_rd_ptr", 32'(rd_ptr), 32'd2);

        // Oversize header is dropped with a single err_len pulse.
        err0 = err_cnt;
        for (int i = 8; i <= 10; i++) put(i);
        commit();
        wait_drain("oversize", 60);
        chk("oversize_err_pulses", 32'(err_cnt - err0), 32'd1);
        chk("oversize_rd_ptr", 32'(rd_ptr), 32'd5);

        // Underflow mid-packet stalls, then reset discards the packet.
        for (int i = 11; i <= 12; i++) put(i);
        commit();
        wait_drain("underflow", 40);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk) #1;
            if (cmd_valid !== 1'b0 || ram_re !== 1'b0) bad = 1'b1;
        end
        chk("underflow_stall", 32'(bad), 32'd0);
        chk("underflow_rd_ptr", 32'(rd_ptr), 32'd7);
        rst = 1'b1;
        wr_ptr = '0;
        wp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("midreset");
        rst = 1'b0;
        for (int i = 13; i <= 14; i++) put(i);
        commit();
        wait_drain("recommit", 40);
        chk("recommit_rd_ptr", 32'(rd_ptr), 32'd2);
        chk("total_err_pulses", 32'(err_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gp_cmd_fetch.md
# gp_cmd_fetch

Command fetch stage of the graphics processor; sits directly downstream of the 2048×16 command buffer RAM. It reads committed words from the RAM read port in ring-buffer order, frames them into packets from the header word, and presents one 16-bit beat at a time to the draw engine over a valid/ready handshake. It returns its consumed pointer upstream so the command writer can detect a full buffer.

## Interface
Parameters:
- ADDR_W, 11, RAM word-address width; ring size is 2**ADDR_W words.
- MAX_LEN, 255, largest legal payload length in words; range 0..255.

Ports:
- clk  in  1  single clock, shared with the RAM read port.
- rst  in  1  reset, synchronous and active-high.
- wr_ptr  in  ADDR_W  upstream commit pointer: next word address the writer will fill.
- rd_ptr  out  ADDR_W  next word address this block will consume.
- ram_re  out  1  RAM read enable.
- ram_raddr  out  ADDR_W  RAM read address.
- ram_rdata  in  16  RAM read data; valid the cycle after ram_re.
- cmd_valid  out  1  beat available.
- cmd_ready  in  1  draw engine accepts the beat.
- cmd_data  out  16  beat word.
- cmd_first  out  1  beat is the packet header.
- cmd_last  out  1  beat is the final beat of the packet.
- cmd_id  out  8  symbol ID of the current packet.
- cmd_len  out  8  payload length of the current packet.
- err_len  out  1  one-cycle pulse: a header was dropped because its length exceeded MAX_LEN.

## Operation
- Header word format: [7:0] symbol ID, [15:8] payload length L. A packet is one header word followed by L payload words.
- Beats: header beat (cmd_first=1), then L payload beats. The final beat has cmd_last=1. For L=0 the header beat has first=last=1.
- cmd_id and cmd_len are loaded from the header. They hold for every beat of that packet.
- Available words: avail = (wr_ptr − rd_ptr) mod 2**ADDR_W. The buffer is empty when avail = 0. Full detection is upstream's job: full when wr_ptr+1 = rd_ptr.
- State machine:
  - IDLE: if avail≠0, go to RD; otherwise stay.
  - RD: ram_re=1, ram_raddr=rd_ptr; go to WAIT.
  - WAIT: ram_rdata is valid in this state.
    - If expecting a header and rdata[15:8] > MAX_LEN: pulse err_len, rd_ptr+1, go to IDLE with no beat. The next word is treated as a header.
    - Otherwise: register rdata into cmd_data, set first/last, go to OUT.
  - OUT: cmd_valid=1. On cmd_valid&&cmd_ready, rd_ptr+1, decrement the remaining count, go to IDLE.
- Packet tracking: an in_pkt flag plus an 8-bit remaining counter. The counter loads L at the header. A beat is last when the remaining count is 0 at the header, or 1 at a payload word.
- Pointer wrap: rd_ptr increments modulo 2**ADDR_W. Packets may straddle address 2047→0.
- Underflow mid-packet: a missing payload word stalls in IDLE. Framing and outputs are unaffected.
- ram_re is 0 in every state except RD. ram_raddr is don't-care outside RD; drive rd_ptr.

## Timing
- Reset values: state IDLE, rd_ptr=0, cmd_valid=0, cmd_data=0, cmd_first=0, cmd_last=0, cmd_id=0, cmd_len=0, err_len=0, ram_re=0, in_pkt=0, remaining=0.
- Reset mid-packet discards the packet immediately. The upstream writer resets wr_ptr on the same rst.
- Latency: wr_ptr becomes non-equal in cycle t → RD at t+1 → WAIT at t+2 → cmd_valid at t+3.
- Throughput: with ready held high and data available, one beat per 3 cycles. Handshake at cycle k → next cmd_valid at k+3.
- While cmd_valid=1 and cmd_ready=0, hold cmd_data, cmd_first, cmd_last, cmd_id, cmd_len and rd_ptr stable. Never deassert cmd_valid without a handshake.
- rd_ptr updates on the edge that ends the handshake (or the err_len cycle). It is visible upstream the following cycle.
- wr_ptr changing in the same cycle as a handshake is legal. avail is recomputed in IDLE from the registered rd_ptr.

## Structure
- Shared package gp_cmd_pkg:
  - packed struct cmd_hdr_t {len[7:0], id[7:0]}
  - CMD_ADDR_W = 11
  - state enum {IDLE, RD, WAIT, OUT}
- The command writer uses the same package.
- Single module. No sub-module is warranted; the ring arithmetic is one subtraction.

## Test plan
- Basic packet: write header 0x0203 (id 3, len 2) and payloads 0xAAAA, 0xBBBB at 0..2; set wr_ptr=3, ready=1 → three beats 0x0203/first, 0xAAAA, 0xBBBB/last; cmd_id=3 and cmd_len=2 on all beats; rd_ptr=3; first cmd_valid 3 cycles after the wr_ptr update.
- Zero-length and backpressure: header 0x0007 with ready=0 for 10 cycles → cmd_valid held and data stable; after ready=1, a single beat with first=last=1; rd_ptr+1.
- Wrap: rd_ptr=wr_ptr=2046; write a 4-word packet at 2046, 2047, 0, 1; wr_ptr=2 → four beats in order; rd_ptr=2.
- Oversize header with MAX_LEN=4: header 0x0501 then a valid header 0x0102 and payload 0x1234 → err_len pulses once with no beat; then the 0x0102 packet delivers two beats.
- Underflow and reset: commit only header 0x0309 and one payload → two beats, then stall with cmd_valid=0. Assert rst → all outputs return to reset values. Recommit a full packet from 0 → delivered normally.
